// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: sends one NBITS packet MSB first on mosi while capturing miso,
// then presents the captured packet on a val/rdy response port.
module spi_initiator #(
    parameter int NBITS = 24,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] req_msg,
    input  logic             req_val,
    output logic             req_rdy,
    output logic [NBITS-1:0] resp_msg,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_parity,
    input  logic [DIV_W-1:0] clk_div,
    output logic             cs,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             busy
);
    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] half_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [NBITS-1:0] tx_sr;
    logic [NBITS-1:0] rx_sr;
    logic             half_done;
    logic             last_bit;
    logic             accept;

    // half_cnt runs 0..div_q, so div_q at its maximum yields 2^DIV_W cycles without overflow
    assign half_done   = (half_cnt == div_q);
    assign last_bit    = (bit_cnt == LAST_BIT);
    assign accept      = req_val && (state == IDLE);
    assign resp_parity = ^resp_msg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        resp_val  = 1'b0;
        cs        = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                req_rdy = !reset;
                if (req_val) state_nxt = SETUP;
            end
            SETUP: begin
                cs   = 1'b0;
                mosi = tx_sr[NBITS-1];
                if (half_done) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                cs   = 1'b0;
                sclk = 1'b1;
                mosi = tx_sr[NBITS-1];
                if (half_done) state_nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                cs   = 1'b0;
                mosi = tx_sr[NBITS-1];
                if (half_done) state_nxt = last_bit ? HOLD : SHIFT_HI;
            end
            HOLD: begin
                cs   = 1'b0;
                mosi = tx_sr[NBITS-1];
                if (half_done) state_nxt = RESP;
            end
            RESP: begin
                resp_val = 1'b1;
                if (resp_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            resp_msg <= '0;
        end else begin
            if (state == IDLE) begin
                half_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != RESP) begin
                half_cnt <= half_done ? '0 : half_cnt + 1'b1;
                if (state == SHIFT_LO && half_done && !last_bit) bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == HOLD && half_done) resp_msg <= rx_sr;
        end
    end

    // The final bit is not shifted out so mosi keeps it through the last low phase and HOLD
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sr <= req_msg;
            div_q <= clk_div;
        end else if (state == SHIFT_HI && half_done) begin
            rx_sr <= {rx_sr[NBITS-2:0], miso};
            if (!last_bit) tx_sr <= {tx_sr[NBITS-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench for spi_initiator: vector table of complete transfers plus
// hand-written reset, response-stall and back-to-back sequences.
`timescale 1ns/1ps
module tb_spi_initiator;
    localparam int NBITS = 24;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NBITS-1:0] req_msg;
    logic             req_val;
    logic             req_rdy;
    logic [NBITS-1:0] resp_msg;
    logic             resp_val;
    logic             resp_rdy;
    logic             resp_parity;
    logic [DIV_W-1:0] clk_div;
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             busy;
    int               miso_mode;   // 0 loopback, 1 tied low, 2 tied high

    int n_checks = 0;
    int n_fail   = 0;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 2);

    spi_initiator #(.NBITS(NBITS), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset),
        .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
        .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_parity(resp_parity), .clk_div(clk_div),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] msg;
        logic [7:0]  div;
        int          mode;
        logic [23:0] exp_msg;
        logic        exp_par;
        int          exp_cs;
        int          exp_t;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transfer; inputs are scrambled right after acceptance to prove they were latched.
    task automatic run_xfer(input string tag, input logic [23:0] msg, input logic [7:0] div,
                            input int mode, input logic [23:0] exp_msg, input logic exp_par,
                            input int exp_cs, input int exp_t, input int stall);
        int   cyc, edges, cslow, hmin, hmax, run, mosi_bad;
        logic prev_sclk;
        miso_mode = mode;
        req_msg   = msg;
        clk_div   = div;
        req_val   = 1'b1;
        check({tag, "_req_rdy"}, 32'(req_rdy), 32'(1));
        @(negedge clk);
        req_val = 1'b0;
        req_msg = ~msg;
        clk_div = div ^ 8'h05;
        cyc = 0; edges = 0; cslow = 0; hmin = 1 << 30; hmax = 0; run = 0; mosi_bad = 0;
        prev_sclk = 1'b0;
        while (!resp_val && cyc < 30000) begin
            if (!cs) cslow++;
            if (cs && mosi) mosi_bad++;
            if (sclk && !prev_sclk) edges++;
            if (sclk) begin
                run++;
            end else if (prev_sclk) begin
                if (run < hmin) hmin = run;
                if (run > hmax) hmax = run;
                run = 0;
            end
            prev_sclk = sclk;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_resp_timeout"}, 32'(cyc < 30000), 32'(1));
        check({tag, "_msg"}, 32'(resp_msg), 32'(exp_msg));
        check({tag, "_parity"}, 32'(resp_parity), 32'(exp_par));
        check({tag, "_edges"}, 32'(edges), 32'(NBITS));
        check({tag, "_cs_low"}, 32'(cslow), 32'(exp_cs));
        check({tag, "_hi_min"}, 32'(hmin), 32'(exp_t));
        check({tag, "_hi_max"}, 32'(hmax), 32'(exp_t));
        check({tag, "_mosi_idle"}, 32'(mosi_bad), 32'(0));
        for (int i = 0; i < stall; i++) begin
            req_val = 1'b1;
            check({tag, "_stall_val"}, 32'(resp_val), 32'(1));
            check({tag, "_stall_msg"}, 32'(resp_msg), 32'(exp_msg));
            check({tag, "_stall_rdy"}, 32'(req_rdy), 32'(0));
            check({tag, "_stall_cs"}, 32'(cs), 32'(1));
            @(negedge clk);
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'(0));
        check({tag, "_idle_val"}, 32'(resp_val), 32'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   cyc, edges, nresp, r1, s2;
        logic prev_sclk;

        vecs[0] = '{24'hA5A5A5, 8'd0,   0, 24'hA5A5A5, 1'b0, 50,    1};
        vecs[1] = '{24'h000001, 8'd3,   2, 24'hFFFFFF, 1'b0, 200,   4};
        vecs[2] = '{24'hC00003, 8'd0,   0, 24'hC00003, 1'b0, 50,    1};
        vecs[3] = '{24'h3C0F0F, 8'd5,   0, 24'h3C0F0F, 1'b0, 300,   6};
        vecs[4] = '{24'hFFFFFF, 8'd2,   1, 24'h000000, 1'b0, 150,   3};
        vecs[5] = '{24'h123456, 8'd1,   0, 24'h123456, 1'b1, 100,   2};
        vecs[6] = '{24'h800001, 8'd255, 0, 24'h800001, 1'b0, 12800, 256};

        reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b0; req_msg = '0; clk_div = '0; miso_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs), 32'(1));
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_resp_val", 32'(resp_val), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_req_rdy", 32'(req_rdy), 32'(0));
        reset = 1'b0;
        #1;
        check("post_rst_req_rdy", 32'(req_rdy), 32'(1));
        check("post_rst_resp_msg", 32'(resp_msg), 32'(0));
        check("post_rst_parity", 32'(resp_parity), 32'(0));
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].msg, vecs[i].div, vecs[i].mode,
                     vecs[i].exp_msg, vecs[i].exp_par, vecs[i].exp_cs, vecs[i].exp_t, 0);
        end

        run_xfer("stall", 24'h000007, 8'd0, 0, 24'h000007, 1'b1, 50, 1, 10);

        // Reset in the high phase of the 10th sclk pulse
        miso_mode = 0; req_msg = 24'hFFFFFF; clk_div = 8'd1; req_val = 1'b1;
        @(negedge clk);
        req_val = 1'b0;
        cyc = 0; edges = 0; prev_sclk = 1'b0;
        while (edges < 10 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (sclk && !prev_sclk) edges++;
            prev_sclk = sclk;
        end
        check("abort_reach_edge10", 32'(edges), 32'(10));
        check("abort_cs_before", 32'(cs), 32'(0));
        reset = 1'b1;
        #1;
        check("abort_cs", 32'(cs), 32'(1));
        check("abort_sclk", 32'(sclk), 32'(0));
        check("abort_mosi", 32'(mosi), 32'(0));
        check("abort_resp_val", 32'(resp_val), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_req_rdy", 32'(req_rdy), 32'(1));
        check("abort_resp_msg", 32'(resp_msg), 32'(0));
        @(negedge clk);
        check("abort_no_resp", 32'(resp_val), 32'(0));
        run_xfer("after_abort", 24'h123456, 8'd0, 0, 24'h123456, 1'b1, 50, 1, 0);

        // Back-to-back: request and response ready both held high
        miso_mode = 0; clk_div = 8'd0; req_msg = 24'h5A5A5A; req_val = 1'b1; resp_rdy = 1'b1;
        @(negedge clk);
        req_msg = 24'h3C3C3C;
        cyc = 0; nresp = 0; r1 = -1; s2 = -1;
        while (nresp < 2 && cyc < 400) begin
            if (resp_val) begin
                if (nresp == 0) begin
                    check("b2b_msg1", 32'(resp_msg), 32'(24'h5A5A5A));
                    r1 = cyc;
                end else begin
                    check("b2b_msg2", 32'(resp_msg), 32'(24'h3C3C3C));
                    req_val = 1'b0;
                end
                nresp++;
            end else if (r1 >= 0 && s2 < 0 && !cs) begin
                s2 = cyc;
            end
            if (r1 >= 0 && cyc == r1 + 1) begin
                check("b2b_gap_cs", 32'(cs), 32'(1));
                check("b2b_gap_req_rdy", 32'(req_rdy), 32'(1));
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_two_resps", 32'(nresp), 32'(2));
        check("b2b_restart_delay", 32'(s2 - r1), 32'(2));
        resp_rdy = 1'b0;
        @(negedge clk);
        check("b2b_final_busy", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_initiator.md
SPI_INITIATOR -- requirements
Module: spi_initiator

Interface
REQ-001 Parameter NBITS, default 24, SHALL set the SPI packet width in bits.
REQ-002 Parameter DIV_W, default 8, SHALL set the width of the clock-divider input.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL be on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 req_msg  input  NBITS  SHALL carry the packet to transmit, MSB first.
REQ-006 req_val / req_rdy  input / output  1 / 1  SHALL form the request val/rdy handshake.
REQ-007 resp_msg  output  NBITS  SHALL carry the packet received on miso.
REQ-008 resp_val / resp_rdy  output / input  1 / 1  SHALL form the response val/rdy handshake.
REQ-009 resp_parity  output  1  SHALL equal the XOR of all bits of resp_msg.
REQ-010 clk_div  input  DIV_W  SHALL set the sclk half-period to T = clk_div+1 clk cycles.
REQ-011 cs / sclk / mosi  output  1 each  SHALL be the SPI chip-select (active-low), serial clock and data-out.
REQ-012 miso  input  1  SHALL be the SPI data-in from the minion.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement SPI mode 0: sclk idles low; the minion samples mosi on sclk rising; mosi changes only while sclk is low.
REQ-015 States SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, RESP.
REQ-016 req_rdy SHALL be 1 only in IDLE; a transfer SHALL start when req_val and req_rdy are both high.
REQ-017 On acceptance, req_msg and clk_div SHALL be latched; later changes to either SHALL NOT affect the transfer in progress.
REQ-018 IDLE->SETUP on acceptance: the next cycle cs=0, sclk=0, mosi=req_msg[NBITS-1]; SETUP SHALL last T cycles.
REQ-019 SHIFT_HI: sclk=1 for T cycles; miso SHALL be sampled into the receive shift register LSB on the last cycle of SHIFT_HI.
REQ-020 SHIFT_LO: sclk=0 for T cycles; on entry mosi SHALL present the next bit; after the NBITS-th SHIFT_LO the state SHALL go to HOLD.
REQ-021 Exactly NBITS sclk rising edges SHALL occur per transfer.
REQ-022 HOLD: cs=0, sclk=0, mosi holds the last bit, for T cycles; then cs=1 and the state SHALL go to RESP.
REQ-023 cs SHALL be low for exactly T*(2*NBITS+2) consecutive cycles per transfer.
REQ-024 RESP: resp_val=1 and resp_msg/resp_parity stable until resp_rdy=1; handshake cycle -> IDLE the next cycle.
REQ-025 While resp_val=1 and resp_rdy=0, req_rdy SHALL stay 0 and no SPI activity SHALL occur.
REQ-026 mosi SHALL be 0 whenever cs=1.
REQ-027 The half-period counter SHALL be DIV_W bits wide; clk_div at its maximum value SHALL give T = 2^DIV_W with no wrap error.

Reset
REQ-028 On reset assertion, including mid-transfer: state=IDLE, cs=1, sclk=0, mosi=0, resp_val=0, busy=0, req_rdy=0 while reset is held.
REQ-029 After reset, resp_msg=0 and resp_parity=0; req_rdy=1 in the first cycle after reset deasserts.
REQ-030 A transfer aborted by reset SHALL produce no response; the next accepted request SHALL start cleanly from SETUP.

Verification
REQ-031 Loopback (miso=mosi), clk_div=0, send 0xA5A5A5 -> resp_msg=0xA5A5A5, resp_parity=0, 24 sclk rising edges, cs low 50 cycles.
REQ-032 miso tied 1, clk_div=3, send 0x000001 -> resp_msg=0xFFFFFF, resp_parity=0, sclk period 8 cycles, cs low 200 cycles.
REQ-033 Loopback, send 0x000007, hold resp_rdy=0 for 10 cycles -> resp_val stays 1, resp_msg=0x000007, resp_parity=1, req_rdy=0, cs=1 throughout the stall.
REQ-034 Change clk_div from 0 to 5 mid-transfer -> sclk half-period stays 1 cycle until cs rises; the next transfer uses T=6.
REQ-035 Assert reset after the 10th sclk rising edge -> cs=1, sclk=0, resp_val=0 immediately; after release, a transfer of 0x123456 in loopback returns 0x123456, resp_parity=1.
REQ-036 Back-to-back: req_val held high with resp_rdy=1 -> the second transfer starts in the cycle after the response handshake; no overlap of cs-low windows.
